// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port frame-buffer scheduler, display reads first, two writers round-robin
// Ports: i_clk/i_rst (sync, active-high); i_disp_req/i_disp_addr -> o_disp_data/o_disp_valid (3-cycle read);
// i_wr_req[1:0], i_wr_addr0/1, i_wr_data0/1 -> o_wr_gnt pulse; o_starved sticky flags;
// o_mem_addr/o_mem_wdata/o_mem_we/i_mem_rdata drive the synchronous RAM port.
module vga_fb_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int STARVE_MAX = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic [1:0]        i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr0,
  input  logic [ADDR_W-1:0] i_wr_addr1,
  input  logic [DATA_W-1:0] i_wr_data0,
  input  logic [DATA_W-1:0] i_wr_data1,
  output logic [1:0]        o_wr_gnt,
  output logic [1:0]        o_starved,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic          last, rd_v1, rd_v2, sel;
  logic [1:0]    elig, gnt_nxt;
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] cnt_nxt [2];
  // the grant still visible this cycle masks the writer's stale request
  always_comb begin
    elig = i_wr_req & ~o_wr_gnt;
    sel = (elig == 2'b11) ? ~last : elig[1];
    gnt_nxt = (i_disp_req || elig == 2'b00) ? 2'b00 : (sel ? 2'b10 : 2'b01);
    for (int k = 0; k < 2; k++)
      cnt_nxt[k] = (elig[k] && !gnt_nxt[k]) ? ((cnt[k] == CW'(STARVE_MAX)) ? cnt[k] : cnt[k] + 1'b1) : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_disp_data <= '0;
      o_disp_valid <= 1'b0;
      o_wr_gnt <= 2'b00;
      o_starved <= 2'b00;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_mem_we <= 1'b0;
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      last <= 1'b1;
      cnt <= '{default: '0};
    end else begin
      rd_v1 <= i_disp_req;
      rd_v2 <= rd_v1;
      o_disp_valid <= rd_v2;
      if (rd_v2) o_disp_data <= i_mem_rdata;
      o_wr_gnt <= gnt_nxt;
      o_mem_we <= |gnt_nxt;
      if (i_disp_req) o_mem_addr <= i_disp_addr;
      else if (|gnt_nxt) begin
        o_mem_addr <= sel ? i_wr_addr1 : i_wr_addr0;
        o_mem_wdata <= sel ? i_wr_data1 : i_wr_data0;
        last <= sel;
      end
      for (int k = 0; k < 2; k++) begin
        cnt[k] <= cnt_nxt[k];
        o_starved[k] <= o_starved[k] | (cnt_nxt[k] == CW'(STARVE_MAX));
      end
    end
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port frame-buffer access scheduler placed between the `VGA_display` pixel fetch path and two pixel writers: the gesture overlay and the text/HUD renderer. It owns the only port of the on-chip frame-buffer RAM. Display reads get absolute priority; the two writers share the remaining slots round-robin. A per-writer sticky starvation flag helps diagnose overlays that never land.

## Interface
- `ADDR_W`, default 15: frame-buffer word address width.
- `DATA_W`, default 8: pixel word width.
- `STARVE_MAX`, default 1023: number of consecutive waiting cycles after which a writer's starvation flag sets.

- `i_clk`  in  1  system clock (CLOCK_50 domain).
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_disp_req`  in  1  display fetch request, one read per high cycle.
- `i_disp_addr`  in  ADDR_W  display fetch address.
- `o_disp_data`  out  DATA_W  fetched pixel.
- `o_disp_valid`  out  1  `o_disp_data` valid; one-cycle pulse per read.
- `i_wr_req`  in  2  write request, one bit per writer.
- `i_wr_addr0`, `i_wr_addr1`  in  ADDR_W  write addresses.
- `i_wr_data0`, `i_wr_data1`  in  DATA_W  write data.
- `o_wr_gnt`  out  2  write accepted; one-cycle pulse.
- `o_starved`  out  2  sticky starvation flags.
- `o_mem_addr`  out  ADDR_W  RAM address.
- `o_mem_wdata`  out  DATA_W  RAM write data.
- `o_mem_we`  out  1  RAM write enable.
- `i_mem_rdata`  in  DATA_W  RAM read data; synchronous RAM, 1-cycle latency.

## Operation
- **Arbitration** is evaluated each cycle on the sampled requests. Priority order:
  - If `i_disp_req` is high, issue a read.
  - Otherwise, grant an eligible writer by round-robin.
  - Otherwise, idle.
- **Eligibility:** writer i is eligible when `i_wr_req[i]=1` and `o_wr_gnt[i]=0` in the current cycle.
  - This masks the stale request that is still visible in the grant cycle.
  - Consequence: at most one grant per writer every 2 cycles.
- **Round-robin pointer `last`:**
  - When both writers are eligible, grant `~last`.
  - `last` updates to the granted index.
  - Reset value `last=1`, so writer 0 wins the first tie.
  - A single eligible writer is granted regardless of `last`.
- **Write issue (registered):** `o_mem_addr`/`o_mem_wdata` are taken from the granted writer, with `o_mem_we=1` and `o_wr_gnt[i]=1` in the same cycle.
- **Read issue (registered):** `o_mem_addr=i_disp_addr`, `o_mem_we=0`.
  - A 2-stage valid pipeline tags the read.
  - `o_disp_data` is registered from `i_mem_rdata`.
- **Idle cycle:** `o_mem_we=0` and `o_mem_addr` holds its last value.
- **Writer handshake:** the writer holds request, address and data stable until it sees `o_wr_gnt[i]`. It may change them, or drop the request, from the following cycle.
- **Starvation counter (per writer):**
  - Width is clog2(STARVE_MAX+1).
  - Increments each cycle the writer is eligible and not granted; saturates at STARVE_MAX.
  - Clears on that writer's grant or when its request is low.
  - On reaching STARVE_MAX, `o_starved[i]` sets and stays set until reset.
- **Mid-operation reset:** in-flight reads are discarded (valid pipeline cleared), and the counters and `last` are reinitialised.

## Timing
- **Reset values:**
  - `o_disp_data=0`, `o_disp_valid=0`, `o_wr_gnt=0`, `o_starved=0`.
  - `o_mem_addr=0`, `o_mem_wdata=0`, `o_mem_we=0`.
  - `last=1`, counters 0.
- **Read latency:** `i_disp_req` high in cycle n gives `o_mem_addr` in n+1, `i_mem_rdata` in n+2, and `o_disp_valid`/`o_disp_data` in n+3.
  - Throughput is 1 read/cycle.
  - Back-to-back reads return in request order.
- **Write latency:** an eligible request in cycle n (with no display request) gives `o_wr_gnt`+`o_mem_we` in n+1.
  - RAM contents update at the end of n+1.
- **Same-address conflict:** a write granted in cycle n+1 followed by a read of that address issued in n+2 returns the new data.
  - No forwarding is required: the RAM is written before the read address is presented.
- **Simultaneous events:**
  - Display plus both writers: read wins and no grant is issued; both writers' counters increment.
  - Display request continuously high: writers are never served, and starvation flags set after STARVE_MAX cycles.

## Test plan
- **Reset state:** assert `i_rst` for 2 cycles with all requests high → all outputs 0 during reset. After release, the first write grant goes to writer 0.
- **Read latency:** preload addr 0x0010=0x5A, pulse `i_disp_req` with addr 0x0010 in cycle 5 → `o_disp_valid=1`, `o_disp_data=0x5A` in cycle 8 only.
- **Round-robin:** both writers hold requests continuously (addr 0x100/0x200, data 0x11/0x22), no display requests → grants alternate 0,1,0,1. Readback gives 0x100=0x11 and 0x200=0x22.
- **Display priority and starvation:** `STARVE_MAX=8`, `i_disp_req` held high, writer 1 requesting → no `o_wr_gnt`. `o_starved=2'b10` from the 9th waiting cycle. The flag stays set after the display request drops and writer 1 is granted.
- **Reset mid-read:** three back-to-back reads, then `i_rst` asserted in the cycle after the last request → no `o_disp_valid` pulse appears after reset.
- **Write-then-read:** writer 0 writes 0x3C to 0x0042, then a display read of 0x0042 is issued the cycle after the grant → returns 0x3C.
